// File: rtl/pipe_stage_hs_pkg.sv
// Shared widths, bubble payloads and steering types for the
// pipeline-stage handshake registers.
package pipe_stage_hs_pkg;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 104;
  localparam int MEM_WB_W = 72;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [IF_ID_W-1:0]  IF_ID_BUBBLE  = {NOP_INST, 32'h0};
  localparam logic [ID_EX_W-1:0]  ID_EX_BUBBLE  = '0;
  localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE = '0;
  localparam logic [MEM_WB_W-1:0] MEM_WB_BUBBLE = '0;

  typedef enum logic [1:0] {
    SEL_HOLD,
    SEL_IN,
    SEL_SKID,
    SEL_CLR
  } ent_sel_e;

  function automatic logic [1:0] occ_f(
    input logic m,
    input logic s
  );
    return {1'b0, m} + {1'b0, s};
  endfunction

endpackage

// File: rtl/pipe_stage_hs_entry.sv
// One payload entry: data + valid flop with load/clear controls.
// An invalid entry always holds BUBBLE.
module pipe_entry
  import pipe_stage_hs_pkg::*;
#(
  parameter int            W      = 64,
  parameter logic [W-1:0]  BUBBLE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         clear_i,
  input  logic [W-1:0] d_i,
  output logic         v_o,
  output logic [W-1:0] q_o
);

  logic         v_q, v_d;
  logic [W-1:0] q_q, q_d;

  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (clear_i) begin
      v_d = 1'b0;
      q_d = BUBBLE;
    end else if (load_i) begin
      v_d = 1'b1;
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      q_q <= BUBBLE;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign v_o = v_q;
  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Pipeline-stage register with valid/ready handshake, flush and
// optional skid entry so in_ready can be registered.
module pipe_stage_hs
  import pipe_stage_hs_pkg::*;
#(
  parameter int                DATA_W = 64,
  parameter int                SKID   = 1,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_q, skid_q;
  logic              main_free, accept;
  logic              m_ld, m_clr;
  logic [DATA_W-1:0] m_d;
  ent_sel_e          msel;

  assign main_free = !main_v | out_ready;
  assign accept    = in_valid & in_ready;

  // Skid always drains first so FIFO order holds.
  always_comb begin
    msel = SEL_HOLD;
    if (flush)           msel = SEL_CLR;
    else if (!main_free) msel = SEL_HOLD;
    else if (skid_v)     msel = SEL_SKID;
    else if (accept)     msel = SEL_IN;
    else                 msel = SEL_CLR;
  end

  assign m_ld  = (msel == SEL_IN) || (msel == SEL_SKID);
  assign m_clr = (msel == SEL_CLR);
  assign m_d   = (msel == SEL_SKID) ? skid_q : in_data;

  pipe_entry #(.W(DATA_W), .BUBBLE(BUBBLE)) u_main (
    .clk     (clk),
    .rst     (rst),
    .load_i  (m_ld),
    .clear_i (m_clr),
    .d_i     (m_d),
    .v_o     (main_v),
    .q_o     (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic s_ld, s_clr;

      always_comb begin
        s_ld  = 1'b0;
        s_clr = flush;
        if (!flush) begin
          if (main_free) begin
            s_ld  = skid_v & accept;
            s_clr = !(skid_v & accept);
          end else begin
            s_ld  = accept;
          end
        end
      end

      pipe_entry #(.W(DATA_W), .BUBBLE(BUBBLE)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (s_ld),
        .clear_i (s_clr),
        .d_i     (in_data),
        .v_o     (skid_v),
        .q_o     (skid_q)
      );

      assign in_ready = !skid_v;
    end else begin : g_noskid
      assign skid_v   = 1'b0;
      assign skid_q   = BUBBLE;
      assign in_ready = main_free;
    end
  endgenerate

  assign out_valid = main_v;
  assign out_data  = main_q;
  assign occupancy = occ_f(main_v, skid_v);

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench: SKID=1/64-bit and SKID=0/7-bit stages share one stimulus
// stream; per-DUT queues hold expected payloads.
module tb_pipe_stage_hs;
  import pipe_stage_hs_pkg::*;

  localparam logic [63:0] BA = 64'h0000_0013_0000_0000;
  localparam logic [6:0]  BB = 7'h55;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, flush;
  logic [63:0] in_data;

  logic        a_ir, a_ov;
  logic [63:0] a_od;
  logic [1:0]  a_occ;
  logic        b_ir, b_ov;
  logic [6:0]  b_od;
  logic [1:0]  b_occ;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [63:0] qa[$];
  logic [6:0]  qb[$];

  always #5 clk = ~clk;

  pipe_stage_hs #(
    .DATA_W(64), .SKID(1), .BUBBLE(IF_ID_BUBBLE)
  ) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (a_ir),
    .in_data   (in_data),
    .out_valid (a_ov),
    .out_ready (out_ready),
    .out_data  (a_od),
    .flush     (flush),
    .occupancy (a_occ)
  );

  pipe_stage_hs #(
    .DATA_W(7), .SKID(0), .BUBBLE(BB)
  ) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (b_ir),
    .in_data   (in_data[6:0]),
    .out_valid (b_ov),
    .out_ready (out_ready),
    .out_data  (b_od),
    .flush     (flush),
    .occupancy (b_occ)
  );

  task automatic chk(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor A: 2-entry skid stage
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("a_valid", a_ov, qa.size() != 0);
      chk("a_occ", a_occ, qa.size());
      chk("a_ready", a_ir, qa.size() < 2);
      if (qa.size() == 0) chk("a_bubble", a_od, BA);
      else chk("a_data", a_od, qa[0]);
      if (flush) begin
        qa.delete();
      end else begin
        logic rdy;
        rdy = qa.size() < 2;
        if (qa.size() != 0 && out_ready) void'(qa.pop_front());
        if (in_valid && rdy) qa.push_back(in_data);
      end
    end
  end

  // Monitor B: single-entry stage
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("b_valid", b_ov, qb.size() != 0);
      chk("b_occ", b_occ, qb.size());
      chk("b_ready", b_ir, qb.size() == 0 || out_ready);
      if (qb.size() == 0) chk("b_bubble", b_od, BB);
      else chk("b_data", b_od, qb[0]);
      if (flush) begin
        qb.delete();
      end else begin
        logic rdy;
        rdy = qb.size() == 0 || out_ready;
        if (qb.size() != 0 && out_ready) void'(qb.pop_front());
        if (in_valid && rdy) qb.push_back(in_data[6:0]);
      end
    end
  end

  task automatic cyc(
    input bit          v,
    input logic [63:0] d,
    input bit          r,
    input bit          f
  );
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] VA = 64'h0000_00A1;
  localparam logic [63:0] VB = 64'h0000_00B2;
  localparam logic [63:0] VC = 64'h0000_00C3;
  localparam logic [63:0] VD = 64'h0000_00D4;

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 64'hDEAD;
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("rst_a_valid", a_ov, 0);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_ready", a_ir, 1);
    chk("rst_a_data", a_od, BA);
    chk("rst_b_data", b_od, BB);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_flush_a", a_ov, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 1; i <= 6; i++) cyc(1'b1, 64'(i), 1'b1, 1'b0);
    chk("stream_a_data", a_od, 64'd6);
    chk("stream_a_occ", a_occ, 1);
    chk("stream_b_data", b_od, 7'd6);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);

    cyc(1'b1, VA, 1'b0, 1'b0);
    cyc(1'b1, VB, 1'b0, 1'b0);
    chk("stall_a_ready", a_ir, 0);
    chk("stall_a_occ", a_occ, 2);
    chk("stall_a_head", a_od, VA);
    chk("stall_b_ready", b_ir, 0);
    chk("stall_b_occ", b_occ, 1);
    cyc(1'b1, VC, 1'b0, 1'b0);
    cyc(1'b1, VB, 1'b1, 1'b0);
    chk("rel_a_head", a_od, VB);
    chk("rel_a_occ", a_occ, 1);
    chk("swap_b_head", b_od, VB[6:0]);
    chk("swap_b_valid", b_ov, 1);
    cyc(1'b1, VC, 1'b1, 1'b0);
    chk("rel_a_c", a_od, VC);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);

    cyc(1'b1, VA, 1'b0, 1'b0);
    cyc(1'b1, VB, 1'b0, 1'b0);
    cyc(1'b1, VD, 1'b1, 1'b1);
    chk("flush_a_valid", a_ov, 0);
    chk("flush_a_occ", a_occ, 0);
    chk("flush_a_data", a_od, BA);
    chk("flush_b_data", b_od, BB);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0);

    cyc(1'b1, VA, 1'b0, 1'b0);
    cyc(1'b1, VB, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_a_valid", a_ov, 0);
    chk("mid_rst_a_occ", a_occ, 0);
    chk("mid_rst_a_ready", a_ir, 1);
    chk("mid_rst_a_data", a_od, BA);
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 64'h0, 1'b1, 1'b0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0);

    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 3) != 0,
          {$urandom, $urandom},
          $urandom_range(0, 2) != 0,
          $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 64'h0, 1'b1, 1'b0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
